// File: rtl/uart_route_arbiter_if.sv
// Bundle of request, line and status signals between the RPi UART routing
// arbiter and the logic around it. The arbiter sits on the slave modport;
// the requesters and line drivers use the master modport.
interface uart_route_arbiter_if;
    logic       rpi_tx;
    logic       xbee_tx;
    logic       gps_tx;
    logic       req_xbee;
    logic       req_gps;
    logic       sel;
    logic       busy;
    logic       grant_xbee;
    logic       grant_gps;
    logic [7:0] switch_cnt;
    logic       forced;

    modport master (
        output rpi_tx,
        output xbee_tx,
        output gps_tx,
        output req_xbee,
        output req_gps,
        input  sel,
        input  busy,
        input  grant_xbee,
        input  grant_gps,
        input  switch_cnt,
        input  forced
    );

    modport slave (
        input  rpi_tx,
        input  xbee_tx,
        input  gps_tx,
        input  req_xbee,
        input  req_gps,
        output sel,
        output busy,
        output grant_xbee,
        output grant_gps,
        output switch_cnt,
        output forced
    );
endinterface

// File: rtl/uart_route_arbiter.sv
// Sequencer for the RPi UART routing switch. Drives select line S
// (sel=1: RPi<->Xbee, sel=0: RPi<->GPS), flipping it only after both lines of
// the active path have been idle for IDLE_BITS bit times, then holding a
// short guard. Time-slices between the two requesters when both are held.
// Optional macro UART_ROUTE_TIMEOUT_EN adds a drain timeout that forces the
// switch when the path never goes quiet; without it DRAIN waits forever and
// forced is tied low.
module uart_route_arbiter #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int IDLE_BITS      = 12,
    parameter int GUARD_BITS     = 2,
    parameter int SLICE_CYCLES   = 5000000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input logic                clk,
    input logic                rst_n,
    uart_route_arbiter_if.slave bus
);

    // Terminal values of each counter; widths are sized to hold them.
    localparam int IDLE_TERM  = IDLE_BITS * CLKS_PER_BIT - 1;
    localparam int GUARD_TERM = GUARD_BITS * CLKS_PER_BIT - 1;
    localparam int SLICE_TERM = SLICE_CYCLES - 1;

    localparam int IDLE_W  = $clog2(IDLE_TERM) + 1;
    localparam int GUARD_W = $clog2(GUARD_TERM) + 1;
    localparam int SLICE_W = $clog2(SLICE_TERM) + 1;

    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TERM);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_TERM);
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICE_TERM);

    // Reject parameter sets that would leave a counter with no terminal value.
    if (CLKS_PER_BIT < 1 || IDLE_BITS < 1 || GUARD_BITS < 1 ||
        SLICE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_route_arbiter: all timing parameters must be at least 1");
    end

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        DRAIN = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t               state, state_n;
    logic                 sel_q, sel_n;
    logic [7:0]           switch_cnt_q, switch_cnt_n;
    logic [SLICE_W-1:0]   slice_cnt, slice_n;
    logic [IDLE_W-1:0]    idle_cnt, idle_n;
    logic [GUARD_W-1:0]   guard_cnt, guard_n;

    logic [1:0] rpi_sync;
    logic [1:0] xbee_sync;
    logic [1:0] gps_sync;
    logic       rpi_s;
    logic       xbee_s;
    logic       gps_s;

    logic       path_idle;
    logic       own_req;
    logic       other_req;
    logic       want_switch;
    logic [7:0] switch_cnt_inc;

`ifdef UART_ROUTE_TIMEOUT_EN
    localparam int TIMEOUT_TERM = TIMEOUT_CYCLES - 1;
    localparam int TIMEOUT_W    = $clog2(TIMEOUT_TERM) + 1;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_TERM);

    logic [TIMEOUT_W-1:0] timeout_cnt, timeout_n;
    logic                 forced_q, forced_n;
`endif

    // Two-flop synchronisers for the asynchronous TX lines, parked at idle (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpi_sync  <= 2'b11;
            xbee_sync <= 2'b11;
            gps_sync  <= 2'b11;
        end else begin
            rpi_sync  <= {rpi_sync[0], bus.rpi_tx};
            xbee_sync <= {xbee_sync[0], bus.xbee_tx};
            gps_sync  <= {gps_sync[0], bus.gps_tx};
        end
    end

    assign rpi_s  = rpi_sync[1];
    assign xbee_s = xbee_sync[1];
    assign gps_s  = gps_sync[1];

    // The path is quiet only when the RPi and the currently routed device are both idle.
    assign path_idle = rpi_s & (sel_q ? xbee_s : gps_s);

    assign other_req   = sel_q ? bus.req_gps : bus.req_xbee;
    assign own_req     = sel_q ? bus.req_xbee : bus.req_gps;
    assign want_switch = other_req & (~own_req | (slice_cnt >= SLICE_LAST));

    assign switch_cnt_inc = (switch_cnt_q == 8'hFF) ? switch_cnt_q : switch_cnt_q + 8'd1;

    // Next-state and counter updates for the HOLD / DRAIN / GUARD sequence.
    always_comb begin
        state_n      = state;
        sel_n        = sel_q;
        switch_cnt_n = switch_cnt_q;
        slice_n      = slice_cnt;
        idle_n       = idle_cnt;
        guard_n      = guard_cnt;
`ifdef UART_ROUTE_TIMEOUT_EN
        timeout_n    = '0;
        forced_n     = forced_q;
`endif

        case (state)
            HOLD: begin
                if (slice_cnt != SLICE_LAST) begin
                    slice_n = slice_cnt + SLICE_W'(1);
                end
                if (want_switch) begin
                    state_n = DRAIN;
                    idle_n  = '0;
                end
            end

            DRAIN: begin
                // An idle completion wins over any request change in the same cycle.
                if (path_idle && (idle_cnt == IDLE_LAST)) begin
                    sel_n        = ~sel_q;
                    switch_cnt_n = switch_cnt_inc;
                    guard_n      = '0;
                    state_n      = GUARD;
`ifdef UART_ROUTE_TIMEOUT_EN
                    forced_n     = 1'b0;
`endif
                end
`ifdef UART_ROUTE_TIMEOUT_EN
                else if (timeout_cnt == TIMEOUT_LAST) begin
                    sel_n        = ~sel_q;
                    switch_cnt_n = switch_cnt_inc;
                    guard_n      = '0;
                    state_n      = GUARD;
                    forced_n     = 1'b1;
                end
`endif
                else if (!want_switch) begin
                    state_n = HOLD;
                end else begin
                    idle_n = path_idle ? idle_cnt + IDLE_W'(1) : '0;
`ifdef UART_ROUTE_TIMEOUT_EN
                    timeout_n = timeout_cnt + TIMEOUT_W'(1);
`endif
                end
            end

            GUARD: begin
                if (guard_cnt == GUARD_LAST) begin
                    state_n = HOLD;
                    slice_n = '0;
                end else begin
                    guard_n = guard_cnt + GUARD_W'(1);
                end
            end

            default: begin
                state_n = HOLD;
            end
        endcase
    end

    // State and counter registers; reset always hands the path back to the GPS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HOLD;
            sel_q        <= 1'b0;
            switch_cnt_q <= 8'd0;
            slice_cnt    <= '0;
            idle_cnt     <= '0;
            guard_cnt    <= '0;
`ifdef UART_ROUTE_TIMEOUT_EN
            timeout_cnt  <= '0;
            forced_q     <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            sel_q        <= sel_n;
            switch_cnt_q <= switch_cnt_n;
            slice_cnt    <= slice_n;
            idle_cnt     <= idle_n;
            guard_cnt    <= guard_n;
`ifdef UART_ROUTE_TIMEOUT_EN
            timeout_cnt  <= timeout_n;
            forced_q     <= forced_n;
`endif
        end
    end

    assign bus.sel        = sel_q;
    assign bus.busy       = (state != HOLD);
    assign bus.grant_xbee = sel_q & (state == HOLD);
    assign bus.grant_gps  = ~sel_q & (state == HOLD);
    assign bus.switch_cnt = switch_cnt_q;

`ifdef UART_ROUTE_TIMEOUT_EN
    assign bus.forced = forced_q;
`else
    assign bus.forced = 1'b0;
`endif

endmodule

// File: tb/tb_uart_route_arbiter.sv
// Directed self-checking bench for uart_route_arbiter with small timing
// parameters (4 clocks/bit, 2 idle bits, 1 guard bit, 100-cycle slice,
// 64-cycle drain timeout). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_uart_route_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    uart_route_arbiter_if bus();

    uart_route_arbiter #(
        .CLKS_PER_BIT   (4),
        .IDLE_BITS      (2),
        .GUARD_BITS     (1),
        .SLICE_CYCLES   (100),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case a test hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_not_busy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reset values, then 200 quiet cycles with no change.
    task automatic test_reset();
        bit bad;
        bus.rpi_tx   = 1'b1;
        bus.xbee_tx  = 1'b1;
        bus.gps_tx   = 1'b1;
        bus.req_xbee = 1'b0;
        bus.req_gps  = 1'b0;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel: got %b want 0", bus.sel); end
        checks++; if (bus.grant_gps !== 1'b1) begin errors++; $display("[TB] FAIL reset_grant_gps: got %b want 1", bus.grant_gps); end
        checks++; if (bus.grant_xbee !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant_xbee: got %b want 0", bus.grant_xbee); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.switch_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_switch_cnt: got %0d want 0", bus.switch_cnt); end
        checks++; if (bus.forced !== 1'b0) begin errors++; $display("[TB] FAIL reset_forced: got %b want 0", bus.forced); end
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (bus.sel !== 1'b0 || bus.busy !== 1'b0 || bus.switch_cnt !== 8'd0 || bus.grant_gps !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold200: sel=%b busy=%b cnt=%0d want 0/0/0 throughout", bus.sel, bus.busy, bus.switch_cnt); end
    endtask

    // Lone Xbee request on an idle path: 8 drain cycles, then 4 guard cycles.
    task automatic test_switch_to_xbee();
        bus.req_xbee = 1'b1;
        step(1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL xb_busy_rise: got %b want 1", bus.busy); end
        step(7);
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("[TB] FAIL xb_sel_early: got %b want 0", bus.sel); end
        step(1);
        checks++; if (bus.sel !== 1'b1) begin errors++; $display("[TB] FAIL xb_sel_toggle: got %b want 1", bus.sel); end
        checks++; if (bus.switch_cnt !== 8'd1) begin errors++; $display("[TB] FAIL xb_switch_cnt: got %0d want 1", bus.switch_cnt); end
        step(3);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL xb_guard_busy: got %b want 1", bus.busy); end
        step(1);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL xb_busy_fall: got %b want 0", bus.busy); end
        checks++; if (bus.grant_xbee !== 1'b1) begin errors++; $display("[TB] FAIL xb_grant: got %b want 1", bus.grant_xbee); end
        bus.req_xbee = 1'b0;
        step(5);
        checks++; if (bus.sel !== 1'b1) begin errors++; $display("[TB] FAIL xb_keep_owner: got %b want 1", bus.sel); end
    endtask

    // GPS traffic keeps DRAIN from completing until the line goes quiet.
    task automatic test_traffic_blocks_drain();
        bit ok;
        bit bad;
        bus.req_gps = 1'b1;
        wait_not_busy(2, ok);
        wait_not_busy(40, ok);
        checks++; if (ok !== 1'b1 || bus.sel !== 1'b0) begin errors++; $display("[TB] FAIL tr_back_to_gps: ok=%b sel=%b want ok=1 sel=0", ok, bus.sel); end
        checks++; if (bus.switch_cnt !== 8'd2) begin errors++; $display("[TB] FAIL tr_cnt2: got %0d want 2", bus.switch_cnt); end
        bus.req_gps  = 1'b0;
        bus.req_xbee = 1'b1;
        bad = 1'b0;
        for (int p = 0; p < 5; p++) begin
            bus.gps_tx = 1'b0;
            step(1);
            if (bus.sel !== 1'b0) bad = 1'b1;
            bus.gps_tx = 1'b1;
            for (int k = 0; k < 5; k++) begin
                step(1);
                if (bus.sel !== 1'b0) bad = 1'b1;
            end
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL tr_sel_during_pulses: sel=%b want 0 throughout", bus.sel); end
        step(4);
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("[TB] FAIL tr_sel_before_8: got %b want 0", bus.sel); end
        step(1);
        checks++; if (bus.sel !== 1'b1) begin errors++; $display("[TB] FAIL tr_sel_after_8: got %b want 1", bus.sel); end
        checks++; if (bus.switch_cnt !== 8'd3) begin errors++; $display("[TB] FAIL tr_cnt3: got %0d want 3", bus.switch_cnt); end
        wait_not_busy(10, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL tr_guard_end: busy=%b want 0", bus.busy); end
        bus.req_xbee = 1'b0;
    endtask

    // Both requests held: each owner keeps the path for the full slice.
    task automatic test_slice();
        bit ok;
        bus.req_gps = 1'b1;
        wait_not_busy(2, ok);
        wait_not_busy(40, ok);
        checks++; if (ok !== 1'b1 || bus.sel !== 1'b0 || bus.switch_cnt !== 8'd4) begin errors++; $display("[TB] FAIL sl_setup: ok=%b sel=%b cnt=%0d want 1/0/4", ok, bus.sel, bus.switch_cnt); end
        bus.req_xbee = 1'b1;
        step(99);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL sl_hold99: busy=%b want 0", bus.busy); end
        step(1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL sl_drain100: busy=%b want 1", bus.busy); end
        step(7);
        checks++; if (bus.sel !== 1'b0) begin errors++; $display("[TB] FAIL sl_sel_early: got %b want 0", bus.sel); end
        step(1);
        checks++; if (bus.sel !== 1'b1 || bus.switch_cnt !== 8'd5) begin errors++; $display("[TB] FAIL sl_first_switch: sel=%b cnt=%0d want 1/5", bus.sel, bus.switch_cnt); end
        step(4);
        checks++; if (bus.busy !== 1'b0 || bus.grant_xbee !== 1'b1) begin errors++; $display("[TB] FAIL sl_xbee_grant: busy=%b grant_xbee=%b want 0/1", bus.busy, bus.grant_xbee); end
        step(99);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL sl_hold99b: busy=%b want 0", bus.busy); end
        step(1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL sl_drain100b: busy=%b want 1", bus.busy); end
        step(8);
        checks++; if (bus.sel !== 1'b0 || bus.switch_cnt !== 8'd6) begin errors++; $display("[TB] FAIL sl_second_switch: sel=%b cnt=%0d want 0/6", bus.sel, bus.switch_cnt); end
        step(4);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL sl_guard_end: busy=%b want 0", bus.busy); end
    endtask

    // Request withdrawn mid-drain: back to HOLD with the owner unchanged.
    task automatic test_drop_mid_drain();
        bit bad;
        bus.req_gps = 1'b0;
        step(1);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL dr_enter: busy=%b want 1", bus.busy); end
        step(3);
        bus.req_xbee = 1'b0;
        step(1);
        checks++; if (bus.busy !== 1'b0 || bus.sel !== 1'b0 || bus.switch_cnt !== 8'd6) begin errors++; $display("[TB] FAIL dr_abort: busy=%b sel=%b cnt=%0d want 0/0/6", bus.busy, bus.sel, bus.switch_cnt); end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.sel !== 1'b0 || bus.busy !== 1'b0 || bus.switch_cnt !== 8'd6) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL dr_stable: sel=%b busy=%b cnt=%0d want 0/0/6", bus.sel, bus.busy, bus.switch_cnt); end
    endtask

    // Asynchronous reset while draining away from the Xbee.
    task automatic test_async_reset();
        bit ok;
        bus.req_xbee = 1'b1;
        wait_not_busy(2, ok);
        wait_not_busy(40, ok);
        checks++; if (ok !== 1'b1 || bus.sel !== 1'b1 || bus.switch_cnt !== 8'd7) begin errors++; $display("[TB] FAIL ar_setup: ok=%b sel=%b cnt=%0d want 1/1/7", ok, bus.sel, bus.switch_cnt); end
        bus.req_xbee = 1'b0;
        bus.req_gps  = 1'b1;
        step(3);
        checks++; if (bus.busy !== 1'b1 || bus.sel !== 1'b1) begin errors++; $display("[TB] FAIL ar_in_drain: busy=%b sel=%b want 1/1", bus.busy, bus.sel); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.sel !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ar_immediate: sel=%b busy=%b want 0/0", bus.sel, bus.busy); end
        checks++; if (bus.switch_cnt !== 8'd0 || bus.grant_gps !== 1'b1) begin errors++; $display("[TB] FAIL ar_values: cnt=%0d grant_gps=%b want 0/1", bus.switch_cnt, bus.grant_gps); end
        @(negedge clk);
        bus.req_gps = 1'b0;
        rst_n = 1'b1;
        step(2);
    endtask

    // RPi line held low during DRAIN: forced switch only with the timeout build.
    task automatic test_timeout();
        bit ok;
        bit bad;
        bus.rpi_tx   = 1'b0;
        bus.req_xbee = 1'b1;
`ifdef UART_ROUTE_TIMEOUT_EN
        step(64);
        checks++; if (bus.sel !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL to_before: sel=%b busy=%b want 0/1", bus.sel, bus.busy); end
        step(1);
        checks++; if (bus.sel !== 1'b1 || bus.forced !== 1'b1 || bus.switch_cnt !== 8'd1) begin errors++; $display("[TB] FAIL to_forced: sel=%b forced=%b cnt=%0d want 1/1/1", bus.sel, bus.forced, bus.switch_cnt); end
        bus.rpi_tx = 1'b1;
        wait_not_busy(10, ok);
        bus.req_xbee = 1'b0;
        bus.req_gps  = 1'b1;
        wait_not_busy(2, ok);
        wait_not_busy(40, ok);
        checks++; if (ok !== 1'b1 || bus.sel !== 1'b0 || bus.forced !== 1'b0 || bus.switch_cnt !== 8'd2) begin errors++; $display("[TB] FAIL to_clear: ok=%b sel=%b forced=%b cnt=%0d want 1/0/0/2", ok, bus.sel, bus.forced, bus.switch_cnt); end
        bus.req_gps = 1'b0;
`else
        step(1);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (bus.sel !== 1'b0 || bus.busy !== 1'b1 || bus.forced !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("[TB] FAIL to_wait: sel=%b busy=%b forced=%b want 0/1/0", bus.sel, bus.busy, bus.forced); end
        bus.rpi_tx = 1'b1;
        wait_not_busy(2, ok);
        wait_not_busy(40, ok);
        checks++; if (ok !== 1'b1 || bus.sel !== 1'b1 || bus.forced !== 1'b0 || bus.switch_cnt !== 8'd1) begin errors++; $display("[TB] FAIL to_release: ok=%b sel=%b forced=%b cnt=%0d want 1/1/0/1", ok, bus.sel, bus.forced, bus.switch_cnt); end
        bus.req_xbee = 1'b0;
`endif
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_switch_to_xbee();
        test_traffic_blocks_drain();
        test_slice();
        test_drop_mid_drain();
        test_async_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
